// File: rtl/i2s_sample_packer.sv
// Packs I2S receive-FIFO samples into a 32-bit valid/ready output stream.
// Supports one sample per word or two 16-bit halves per word, with frame marking and idle flush.
module i2s_sample_packer #(
   parameter int FW = 8,
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          pack_mode,
   input  logic [FW-1:0] frame_len,
   input  logic [TW-1:0] flush_timeout,
   input  logic          fifo_empty,
   input  logic [31:0]   fifo_rdata,
   output logic          fifo_rd,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [31:0]   m_data,
   output logic          m_last,
   output logic          half_pending
);

   logic          m_valid_q, m_valid_d;
   logic [31:0]   m_data_q, m_data_d;
   logic          m_last_q, m_last_d;
   logic          half_pending_q, half_pending_d;
   logic [15:0]   half_q, half_d;
   logic [FW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] idle_q, idle_d;

   logic          out_free;
   logic          accept;
   logic          pop;
   logic          load;
   logic [31:0]   load_data;

   // The first half of a pair never touches the output register, so it may pop under backpressure.
   assign out_free = ~m_valid_q | m_ready;
   assign accept   = (pack_mode & ~half_pending_q) ? 1'b1 : out_free;
   assign pop      = rst_n & en & ~fifo_empty & accept;

   assign fifo_rd      = pop;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_last       = m_last_q;
   assign half_pending = half_pending_q;

   always_comb begin
      m_valid_d      = m_valid_q;
      m_data_d       = m_data_q;
      m_last_d       = m_last_q;
      half_pending_d = half_pending_q;
      half_d         = half_q;
      cnt_d          = cnt_q;
      idle_d         = idle_q;
      load           = 1'b0;
      load_data      = '0;

      if (!en) begin
         half_pending_d = 1'b0;
         half_d         = '0;
         cnt_d          = '0;
         idle_d         = '0;
      end else if (!pack_mode) begin
         half_pending_d = 1'b0;
         half_d         = '0;
         idle_d         = '0;
         if (pop) begin
            load      = 1'b1;
            load_data = fifo_rdata;
         end
      end else if (pop) begin
         idle_d = '0;
         if (half_pending_q) begin
            load           = 1'b1;
            load_data      = {fifo_rdata[15:0], half_q};
            half_pending_d = 1'b0;
            half_d         = '0;
         end else begin
            half_d         = fifo_rdata[15:0];
            half_pending_d = 1'b1;
         end
      end else if (half_pending_q) begin
         // Once the timeout is reached the counter parks there until the output frees up.
         if ((flush_timeout != '0) && (idle_q == flush_timeout)) begin
            if (out_free) begin
               load           = 1'b1;
               load_data      = {16'h0000, half_q};
               half_pending_d = 1'b0;
               half_d         = '0;
               idle_d         = '0;
            end
         end else begin
            idle_d = idle_q + TW'(1);
         end
      end

      if (load) begin
         m_valid_d = 1'b1;
         m_data_d  = load_data;
         if (frame_len == '0) begin
            m_last_d = 1'b0;
            cnt_d    = '0;
         end else if (cnt_q == (frame_len - FW'(1))) begin
            m_last_d = 1'b1;
            cnt_d    = '0;
         end else begin
            m_last_d = 1'b0;
            cnt_d    = cnt_q + FW'(1);
         end
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q      <= 1'b0;
         m_data_q       <= '0;
         m_last_q       <= 1'b0;
         half_pending_q <= 1'b0;
         half_q         <= '0;
         cnt_q          <= '0;
         idle_q         <= '0;
      end else begin
         m_valid_q      <= m_valid_d;
         m_data_q       <= m_data_d;
         m_last_q       <= m_last_d;
         half_pending_q <= half_pending_d;
         half_q         <= half_d;
         cnt_q          <= cnt_d;
         idle_q         <= idle_d;
      end
   end

endmodule

// File: doc/i2s_sample_packer.md
I2S_SAMPLE_PACKER -- requirements
Module: i2s_sample_packer

Interface
REQ-001 Parameter FW, default 8: width of the frame-length input and the internal word counter.
REQ-002 Parameter TW, default 16: width of the flush-timeout input and the idle counter.
REQ-003 clk  in  1  single clock; every register in the block is clocked on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 en  in  1  block enable.
REQ-006 pack_mode  in  1  selects the output format.
  - 0: one 32-bit sample per output word.
  - 1: two 16-bit samples per output word.
REQ-007 frame_len  in  FW  number of output words per frame; 0 means unframed.
REQ-008 flush_timeout  in  TW  idle cycles before a held half-word is flushed; 0 disables the flush.
REQ-009 fifo_empty  in  1  empty flag of the I2S receive FIFO.
REQ-010 fifo_rdata  in  32  head entry of the I2S receive FIFO.
  - The FIFO is first-word-fall-through: fifo_rdata is valid whenever fifo_empty=0.
REQ-011 fifo_rd  out  1  pop strobe to the I2S receive FIFO.
  - One pop per cycle in which it is high.
REQ-012 m_valid  out  1  output stream valid.
REQ-013 m_ready  in  1  output stream ready, driven by the sink.
REQ-014 m_data  out  32  output stream data.
REQ-015 m_last  out  1  marks the final word of a frame.
REQ-016 half_pending  out  1  a low half-word is held, waiting for its pair.

Function
REQ-017 fifo_rd SHALL be combinational: en & ~fifo_empty & accept.
  - pack_mode=0: accept = ~m_valid | m_ready.
  - pack_mode=1 with no half held: accept = 1.
  - pack_mode=1 with a half held: accept = ~m_valid | m_ready.
REQ-018 A "load" writes the output register and sets m_valid. m_data, m_last and m_valid SHALL be registered.
  - pack_mode=0: a pop loads m_data=fifo_rdata; m_valid rises on the next edge (latency 1 cycle).
  - pack_mode=1, first pop: fifo_rdata[15:0] goes to the half register; half_pending=1; m_valid is unchanged.
  - pack_mode=1, second pop: loads m_data={fifo_rdata[15:0], half}; half_pending=0.
REQ-019 m_valid SHALL clear on an edge with m_valid & m_ready and no simultaneous load.
  - Simultaneous accept and load: m_valid stays 1 and the new data is presented (full throughput, one word per cycle).
REQ-020 While m_valid=1 & m_ready=0, m_data and m_last SHALL hold stable.
REQ-021 Load counter (FW bits) increments on every load.
  - m_last is loaded as (counter == frame_len-1).
  - When m_last is loaded as 1, the counter wraps to 0.
  - frame_len=0: m_last is always 0 and the counter stays 0.
REQ-022 Idle counter (TW bits) runs while half_pending=1 and no pop occurs; any pop clears it.
  - When the idle counter equals flush_timeout (nonzero) and the output register is free (~m_valid | m_ready), the block loads m_data={16'h0000, half}.
  - This flush load clears half_pending and counts as a normal load for m_last.
  - If the output register is not free, the flush waits.
REQ-023 When en=0, fifo_rd SHALL be 0.
  - half_pending, the half register, the load counter and the idle counter clear on the next edge.
  - A word already in the output register stays valid until accepted.
REQ-024 If pack_mode=0 while half_pending=1, the held half SHALL be discarded on the next edge without a load.
REQ-025 A pop and a flush SHALL never load in the same cycle; the pop has priority and pairs with the held half.
REQ-026 fifo_empty=1 SHALL stall the block with all state retained; fifo_rd=0.

Reset
REQ-027 On rst_n low, all of the following SHALL clear asynchronously: m_valid=0, m_data=0, m_last=0, half_pending=0, the half register, the load counter and the idle counter.
REQ-028 A reset mid-frame or mid-pair SHALL discard all held data; the first load after reset is frame word 0.
REQ-029 fifo_rd SHALL be 0 while rst_n=0, regardless of fifo_empty.

Verification
REQ-030 Passthrough: pack_mode=0, m_ready=1, FIFO holds 0x11111111 then 0x22222222 -> two pops on consecutive cycles; m_data=0x11111111 then 0x22222222 on consecutive cycles, each one cycle after its pop.
REQ-031 Packing: pack_mode=1, samples 0x0000AAAA then 0x0000BBBB -> a single output word m_data=0xBBBBAAAA; half_pending is 1 between the two pops.
REQ-032 Backpressure: m_ready=0 for 5 cycles with FIFO non-empty, pack_mode=0 -> exactly one pop; m_data stable for all 5 cycles; no word lost or duplicated after m_ready returns to 1.
REQ-033 Framing: frame_len=3, 7 words streamed -> m_last=1 on words 3 and 6 only; word 7 carries m_last=0.
REQ-034 Flush: pack_mode=1, flush_timeout=4, one sample 0x1234 then FIFO empty -> m_data=0x00001234 loaded after 4 idle cycles; half_pending returns to 0.
REQ-035 Reset mid-pair: half held, rst_n pulsed low -> half_pending=0 and m_valid=0 immediately; the next two samples form a fresh pair carrying frame word 0 semantics.
